exec_writeback_seq: RTL

EXEC_WRITEBACK_SEQ -- requirements
Module: exec_writeback_seq

---
 rtl/exec_writeback_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/exec_writeback_seq.sv
// Three-phase execute/writeback sequencer: latches an instruction, presents its operands to an
// external combinational ALU, registers the ALU result and flags, then commits them to the register file and PSR.
module exec_writeback_seq #(
    parameter int NREGS = 16,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   in_op,
    input  logic [3:0]   in_rdest,
    input  logic [3:0]   in_rsrc,
    input  logic         in_imm_en,
    input  logic [W-1:0] in_imm,
    output logic [4:0]   alu_op,
    output logic [W-1:0] alu_rsrc,
    output logic [W-1:0] alu_rdest,
    input  logic [W-1:0] alu_out,
    input  logic [4:0]   alu_flags,
    output logic [4:0]   psr,
    output logic         done,
    output logic         illegal,
    input  logic [3:0]   dbg_idx,
    output logic [W-1:0] dbg_data
);

    // state | meaning
    // IDLE  | waiting for an instruction, in_ready high
    // EXEC  | operands driven to the ALU, result captured at the end of the cycle
    // WB    | result/flags committed, done (and illegal) pulse
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_CMP  = 5'd2;
    localparam logic [4:0] OP_LAST = 5'd9;

    state_t         state_q, state_d;
    logic [4:0]     op_q, op_d;
    logic [3:0]     rdest_idx_q, rdest_idx_d;
    logic [3:0]     rsrc_idx_q, rsrc_idx_d;
    logic           imm_en_q, imm_en_d;
    logic [W-1:0]   imm_q, imm_d;
    logic [W-1:0]   res_q, res_d;
    logic [4:0]     flags_q, flags_d;
    logic [4:0]     psr_q, psr_d;
    logic [4:0]     alu_op_q, alu_op_d;
    logic [W-1:0]   alu_rsrc_q, alu_rsrc_d;
    logic [W-1:0]   alu_rdest_q, alu_rdest_d;
    logic [W-1:0]   regs_q [NREGS];
    logic [W-1:0]   regs_d [NREGS];

    logic           accept;
    logic           op_illegal;
    logic [W-1:0]   opnd_rdest;
    logic [W-1:0]   opnd_rsrc;

    assign accept     = in_valid && (state_q == IDLE);
    assign op_illegal = (op_q > OP_LAST);
    assign opnd_rdest = regs_q[rdest_idx_q];
    assign opnd_rsrc  = imm_en_q ? imm_q : regs_q[rsrc_idx_q];

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rdest_idx_d = rdest_idx_q;
        rsrc_idx_d  = rsrc_idx_q;
        imm_en_d    = imm_en_q;
        imm_d       = imm_q;
        res_d       = res_q;
        flags_d     = flags_q;
        psr_d       = psr_q;
        alu_op_d    = alu_op_q;
        alu_rsrc_d  = alu_rsrc_q;
        alu_rdest_d = alu_rdest_q;
        regs_d      = regs_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d        = in_op;
                    rdest_idx_d = in_rdest;
                    rsrc_idx_d  = in_rsrc;
                    imm_en_d    = in_imm_en;
                    imm_d       = in_imm;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                res_d       = alu_out;
                flags_d     = alu_flags;
                // Snapshot the ALU drive so it holds steady once EXEC ends.
                alu_op_d    = op_q;
                alu_rsrc_d  = opnd_rsrc;
                alu_rdest_d = opnd_rdest;
                state_d     = WB;
            end
            WB: begin
                if (!op_illegal && op_q != OP_CMP) begin
                    regs_d[rdest_idx_q] = res_q;
                end
                if (op_q == OP_ADD || op_q == OP_SUB) begin
                    psr_d = flags_q;
                end else if (op_q == OP_CMP) begin
                    // {N,Z,F,L,C}: compare updates N, Z, L only.
                    psr_d = {flags_q[4], flags_q[3], psr_q[2], flags_q[1], psr_q[0]};
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            rdest_idx_q <= '0;
            rsrc_idx_q  <= '0;
            imm_en_q    <= 1'b0;
            imm_q       <= '0;
            res_q       <= '0;
            flags_q     <= '0;
            psr_q       <= '0;
            alu_op_q    <= '0;
            alu_rsrc_q  <= '0;
            alu_rdest_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rdest_idx_q <= rdest_idx_d;
            rsrc_idx_q  <= rsrc_idx_d;
            imm_en_q    <= imm_en_d;
            imm_q       <= imm_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            psr_q       <= psr_d;
            alu_op_q    <= alu_op_d;
            alu_rsrc_q  <= alu_rsrc_d;
            alu_rdest_q <= alu_rdest_d;
            regs_q      <= regs_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign alu_op    = (state_q == EXEC) ? op_q       : alu_op_q;
    assign alu_rsrc  = (state_q == EXEC) ? opnd_rsrc  : alu_rsrc_q;
    assign alu_rdest = (state_q == EXEC) ? opnd_rdest : alu_rdest_q;
    assign psr       = psr_q;
    assign done      = (state_q == WB);
    assign illegal   = (state_q == WB) && op_illegal;
    assign dbg_data  = regs_q[dbg_idx];

endmodule
